// File: rtl/config_reg_bank.sv
// config_reg_bank: NUM_REGS x DATA_W configuration register bank.
//
// Each register has its own reset value (RESET_VALS) and a per-bit read-only
// mask (RO_MASK). Accesses arrive on a valid/ready request port. Each accepted
// request gets exactly one registered response, in the cycle after the accept.
// A hardware clear sequencer restores the reset values one register per cycle.
//
// Optional feature macro: CFG_LOCK_EN. When it is defined, registers flagged in
// LOCK_MASK reject writes while lock is high. When it is undefined, the lock
// port and LOCK_MASK have no effect.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   req_valid   in   request present
//   req_ready   out  request can be accepted this cycle
//   req_write   in   1 = write, 0 = read
//   address     in   [ADDR_W-1:0] register index
//   data_in     in   [DATA_W-1:0] write data
//   clear_start in   pulse: restore all reset values
//   lock        in   write lock (CFG_LOCK_EN only)
//   rsp_valid   out  one-cycle response strobe
//   data_out    out  [DATA_W-1:0] read data / write read-back
//   rsp_err     out  response error flag, valid with rsp_valid
//   clear_busy  out  clear sequence in progress
module config_reg_bank #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS =
    {16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 16'hFFFF},
  parameter logic [NUM_REGS*DATA_W-1:0] RO_MASK   = '0,
  parameter logic [NUM_REGS-1:0]        LOCK_MASK = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear_start,
  input  logic              lock,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              rsp_err,
  output logic              clear_busy
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t                       state_q, state_d;
  logic [ADDR_W-1:0]            idx_q, idx_d;
  logic [NUM_REGS*DATA_W-1:0]   regs_q, regs_d;
  logic                         rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]            data_out_q, data_out_d;
  logic                         rsp_err_q, rsp_err_d;

  logic              accept;
  logic              addr_legal;
  logic              lock_hit;
  logic [DATA_W-1:0] sel_cur;
  logic [DATA_W-1:0] sel_ro;
  logic [DATA_W-1:0] wr_val;

  // clear_start masks ready combinationally, so a request in the same cycle
  // as a clear pulse is never accepted.
  assign req_ready  = (state_q == S_IDLE) && !clear_start;
  assign accept     = req_valid && req_ready;
  assign clear_busy = (state_q == S_CLEAR);
  assign addr_legal = ({1'b0, address} < (ADDR_W + 1)'(NUM_REGS));

  // Select the addressed register and its read-only mask.
  always_comb begin
    sel_cur = '0;
    sel_ro  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (address == ADDR_W'(i)) begin
        sel_cur = regs_q[i*DATA_W +: DATA_W];
        sel_ro  = RO_MASK[i*DATA_W +: DATA_W];
      end
    end
  end

  // Read-only bits keep their current value on a write.
  assign wr_val = (sel_cur & sel_ro) | (data_in & ~sel_ro);

`ifdef CFG_LOCK_EN
  always_comb begin
    lock_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (address == ADDR_W'(i)) lock_hit = lock && LOCK_MASK[i];
    end
  end
`else
  // The lock input and LOCK_MASK are deliberately left unconnected.
  logic unused_lock;
  assign unused_lock = lock ^ (^LOCK_MASK);
  assign lock_hit    = 1'b0;
`endif

  // Next state: FSM, clear index, register array and response.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    regs_d      = regs_q;
    rsp_valid_d = accept;
    data_out_d  = data_out_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (clear_start) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (idx_q == ADDR_W'(i))
            regs_d[i*DATA_W +: DATA_W] = RESET_VALS[i*DATA_W +: DATA_W];
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Requests are only accepted in IDLE, so this never collides with a
    // clear-sequence register update.
    if (accept) begin
      if (!addr_legal) begin
        data_out_d = '0;
        rsp_err_d  = 1'b1;
      end else if (req_write && !lock_hit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (address == ADDR_W'(i)) regs_d[i*DATA_W +: DATA_W] = wr_val;
        end
        data_out_d = wr_val;
        rsp_err_d  = 1'b0;
      end else begin
        // A read, or a write blocked by the lock: return the current value.
        data_out_d = sel_cur;
        rsp_err_d  = lock_hit && req_write;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      regs_q      <= RESET_VALS;
      rsp_valid_q <= 1'b0;
      data_out_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      regs_q      <= regs_d;
      rsp_valid_q <= rsp_valid_d;
      data_out_q  <= data_out_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign data_out  = data_out_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_config_reg_bank.sv
// Self-checking bench for config_reg_bank.
// Uses 8 registers with a 4-bit address, so addresses 8..15 are out of range.
// Register 7 carries a read-only mask of FF00; register 4 is lockable.
module tb_config_reg_bank;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AW = 4;
  localparam logic [NR*DW-1:0] RV =
    {16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 16'hFFFF};
  localparam logic [NR*DW-1:0] RO = {16'hFF00, 112'h0};
  localparam logic [NR-1:0]    LM = 8'h10;
`ifdef CFG_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data_in = '0;
  logic          clear_start = 1'b0;
  logic          lock = 1'b0;
  logic          rsp_valid;
  logic [DW-1:0] data_out;
  logic          rsp_err;
  logic          clear_busy;

  config_reg_bank #(
    .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW),
    .RESET_VALS(RV), .RO_MASK(RO), .LOCK_MASK(LM)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .address(address), .data_in(data_in),
    .clear_start(clear_start), .lock(lock), .rsp_valid(rsp_valid),
    .data_out(data_out), .rsp_err(rsp_err), .clear_busy(clear_busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: expected response and the cycle of the accept.
  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    int            c;
  } exp_t;
  exp_t sb[$];

  logic [DW-1:0] mdl [NR];

  task automatic mdl_reset();
    for (int i = 0; i < NR; i++) mdl[i] = RV[i*DW +: DW];
  endtask

  // Each response must show up in the cycle right after its accept.
  always @(negedge clk) begin
    if (!reset) begin
      logic exp_v;
      exp_v = (sb.size() > 0) && (sb[0].c + 1 == cyc);
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_v});
      if (exp_v) begin
        exp_t e;
        e = sb.pop_front();
        if (rsp_valid) begin
          chk("data_out", {16'b0, data_out}, {16'b0, e.d});
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.e});
        end
      end
    end
  end

  // Drive one request starting just after a rising edge. The model is updated
  // at the negedge before the accept edge.
  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    logic [DW-1:0] ro, nv;
    req_valid = 1'b1;
    req_write = wr;
    address   = a;
    data_in   = d;
    @(negedge clk);
    chk("req_ready", {31'b0, req_ready}, 32'd1);
    if (req_ready) begin
      e.c = cyc;
      if (int'(a) >= NR) begin
        e.d = '0;
        e.e = 1'b1;
      end else if (!wr) begin
        e.d = mdl[a];
        e.e = 1'b0;
      end else if (LOCK_EN && lock && LM[a]) begin
        e.d = mdl[a];
        e.e = 1'b1;
      end else begin
        ro = RO[int'(a)*DW +: DW];
        nv = (mdl[a] & ro) | (d & ~ro);
        mdl[a] = nv;
        e.d = nv;
        e.e = 1'b0;
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < NR; i++) send(1'b0, AW'(i), '0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    mdl_reset();
    // Outputs while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_data_out", {16'b0, data_out}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_clear_busy", {31'b0, clear_busy}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    // Reset values, then back-to-back inverse writes and a read-back.
    read_all();
    idle(2);
    for (int i = 0; i < NR; i++) send(1'b1, AW'(i), ~RV[i*DW +: DW]);
    read_all();
    idle(2);

    // Read-only mask on register 7, and read-after-write on the next cycle.
    send(1'b1, 4'd7, 16'h1234);
    send(1'b0, 4'd7, '0);
    send(1'b1, 4'd2, 16'hBEEF);
    send(1'b0, 4'd2, '0);

    // Out-of-range accesses change nothing and report an error.
    send(1'b1, 4'd8, 16'h5555);
    send(1'b0, 4'd15, '0);
    send(1'b1, 4'd15, 16'hAAAA);
    read_all();
    idle(2);

    // Lock on register 4; the model ignores it when the feature is compiled out.
    lock = 1'b1;
    send(1'b1, 4'd4, 16'h1111);
    send(1'b1, 4'd5, 16'h2222);
    lock = 1'b0;
    send(1'b1, 4'd4, 16'h3333);
    send(1'b0, 4'd4, '0);
    idle(2);

    // A write accepted right before the clear still responds normally.
    // The clear pulse arrives together with a request that must not be accepted.
    send(1'b1, 4'd6, 16'h6666);
    clear_start = 1'b1;
    req_valid   = 1'b1;
    req_write   = 1'b0;
    address     = 4'd1;
    @(negedge clk);
    chk("ready_on_clear", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    req_valid   = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!clear_busy) break;
      cnt++;
      chk("ready_in_clear", {31'b0, req_ready}, 32'd0);
      // A second clear pulse mid-sequence must not extend it.
      clear_start = (cnt == 3);
    end
    clear_start = 1'b0;
    chk("clear_len", cnt, NR);
    mdl_reset();
    @(posedge clk);
    #1;
    read_all();
    idle(2);

    // Modify registers, then assert reset during the 4th clear cycle.
    for (int i = 0; i < NR; i++) send(1'b1, AW'(i), 16'h0F0F ^ 16'(i));
    clear_start = 1'b1;
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    chk("clear_busy_on", {31'b0, clear_busy}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {31'b0, clear_busy}, 32'd0);
    chk("mid_rst_data", {16'b0, data_out}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mdl_reset();
    @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("post_rst_busy", {31'b0, clear_busy}, 32'd0);
    @(posedge clk);
    #1;
    read_all();
    idle(3);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
